// File: rtl/ptcalc_thread_sched_pkg.sv
// Shared MTC constants and types for the pT-calc thread scheduler.
// Channel width must be able to hold the thread count, which doubles as the "no thread" code.
package ptcalc_thread_sched_pkg;

  localparam int PL2MTC_PROCESS_CH_LEN  = 4;
  localparam int MTC_DROP_CNT_W         = 16;
  localparam int MTC_THREAD_TIMEOUT_DEF = 64;

  typedef logic [PL2MTC_PROCESS_CH_LEN-1:0] ch_t;
  typedef logic [MTC_DROP_CNT_W-1:0]        drop_cnt_t;

  function automatic drop_cnt_t sat_add(input drop_cnt_t a, input drop_cnt_t b);
    logic [MTC_DROP_CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[MTC_DROP_CNT_W] ? '1 : sum[MTC_DROP_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/ptcalc_thread_timer.sv
// Per-thread ownership: busy bit plus watchdog that force-releases a thread
// whose done pulse never arrives.
module ptcalc_thread_timer #(
  parameter int c_THREAD_TIMEOUT = 64
) (
  input  logic clock,
  input  logic rst,
  input  logic grant_i,
  input  logic done_i,
  output logic busy_o,
  output logic spurious_o
);

  localparam int CNT_W = $clog2(c_THREAD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(c_THREAD_TIMEOUT - 1);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (grant_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
    end else if (busy_q) begin
      // A done pulse coinciding with the timeout is a single release.
      if (done_i || cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset clears control state and counter alike.
  always_ff @(posedge clock) begin
    if (!rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign spurious_o = done_i & ~busy_q;

endmodule

// File: rtl/ptcalc_thread_sched.sv
// Allocates shared pT-calc threads to SL candidate requesters: fixed slot
// priority, round-robin thread choice, registered grants, per-thread watchdog.
module ptcalc_thread_sched
  import ptcalc_thread_sched_pkg::*;
#(
  parameter int c_NUM_THREADS    = 3,
  parameter int c_MAX_NUM_SL     = 3,
  parameter int c_THREAD_TIMEOUT = MTC_THREAD_TIMEOUT_DEF
) (
  input  logic                             clock,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [c_MAX_NUM_SL-1:0]          slc_req,
  input  logic [c_NUM_THREADS-1:0]         thread_done,
  output logic [c_MAX_NUM_SL-1:0]          grant_vld,
  output logic [PL2MTC_PROCESS_CH_LEN-1:0] grant_ch [c_MAX_NUM_SL],
  output logic [c_NUM_THREADS-1:0]         thread_busy,
  output logic [MTC_DROP_CNT_W-1:0]        drop_cnt,
  output logic                             err_spurious_done
);

  localparam ch_t CH_NONE = ch_t'(c_NUM_THREADS);
  localparam int  TIDX_W  = (c_NUM_THREADS > 1) ? $clog2(c_NUM_THREADS) : 1;

  logic [c_MAX_NUM_SL-1:0]  grant_vld_q, grant_vld_d;
  ch_t                      grant_ch_q [c_MAX_NUM_SL];
  ch_t                      grant_ch_d [c_MAX_NUM_SL];
  ch_t                      rr_ptr_q, rr_ptr_d;
  drop_cnt_t                drop_cnt_q, drop_cnt_d, drop_inc;
  logic                     err_q;
  logic [c_NUM_THREADS-1:0] busy_w, spurious_w, grant_thread, taken;
  logic                     found;
  int                       idx;

  always_comb begin
    taken        = busy_w;
    grant_thread = '0;
    rr_ptr_d     = rr_ptr_q;
    drop_inc     = '0;
    found        = 1'b0;
    idx          = 0;
    for (int s = 0; s < c_MAX_NUM_SL; s++) begin
      grant_vld_d[s] = 1'b0;
      grant_ch_d[s]  = CH_NONE;
      found          = 1'b0;
      if (slc_req[s] && enable) begin
        // Every slot searches from rr_ptr; threads taken by higher slots are masked.
        for (int k = 0; k < c_NUM_THREADS; k++) begin
          idx = int'(rr_ptr_q) + k;
          if (idx >= c_NUM_THREADS) idx = idx - c_NUM_THREADS;
          if (!found && !taken[TIDX_W'(idx)]) begin
            found                      = 1'b1;
            taken[TIDX_W'(idx)]        = 1'b1;
            grant_thread[TIDX_W'(idx)] = 1'b1;
            grant_vld_d[s]             = 1'b1;
            grant_ch_d[s]              = ch_t'(idx);
            rr_ptr_d                   = (idx == c_NUM_THREADS - 1) ? '0 : ch_t'(idx + 1);
          end
        end
      end
      if (slc_req[s] && !found) drop_inc = drop_inc + drop_cnt_t'(1);
    end
    drop_cnt_d = sat_add(drop_cnt_q, drop_inc);
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      grant_vld_q <= '0;
      rr_ptr_q    <= '0;
      drop_cnt_q  <= '0;
      err_q       <= 1'b0;
      for (int s = 0; s < c_MAX_NUM_SL; s++) grant_ch_q[s] <= CH_NONE;
    end else begin
      grant_vld_q <= grant_vld_d;
      grant_ch_q  <= grant_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      drop_cnt_q  <= drop_cnt_d;
      err_q       <= err_q | (|spurious_w);
    end
  end

  for (genvar t = 0; t < c_NUM_THREADS; t++) begin : g_timer
    ptcalc_thread_timer #(
      .c_THREAD_TIMEOUT(c_THREAD_TIMEOUT)
    ) u_timer (
      .clock     (clock),
      .rst       (rst),
      .grant_i   (grant_thread[t]),
      .done_i    (thread_done[t]),
      .busy_o    (busy_w[t]),
      .spurious_o(spurious_w[t])
    );
  end

  assign grant_vld         = grant_vld_q;
  assign grant_ch          = grant_ch_q;
  assign thread_busy       = busy_w;
  assign drop_cnt          = drop_cnt_q;
  assign err_spurious_done = err_q;

endmodule
